gcd_controller: RTL and testbench
=================================

// Module: gcd_controller
// PURPOSE
//  Control FSM for the subtractive GCD datapath (GCD_datapath): drives ldA/ldB/sel1/sel2/sel_in,
//  consumes its lt/gt/eq flags. Accepts two operands over a valid/ready handshake, iterates
//  until A==B, pulses done. Zero-operand guard and iteration watchdog prevent infinite loops.
// PARAMETERS
//  WIDTH     16    operand width; must match datapath data_in.
//  MAX_ITER  1024  max subtract cycles before abort with err.
//  ITER_W    11    iter_count width; must be >= $clog2(MAX_ITER+1).
// PORTS
//  clk         in   1       rising-edge clock shared with the datapath.
//  rst_n       in   1       asynchronous, active-low reset.
//  start       in   1       begin a GCD run; sampled only in IDLE.
//  op_valid    in   1       operand on op_data is valid (A first, then B).
//  op_data     in   WIDTH   operand value, also wired to datapath data_in; used only for zero check.
//  op_ready    out  1       controller accepts an operand this cycle.
//  gt, lt, eq  in   1 each  datapath compare flags (A>B, A<B, A==B).
//  ldA, ldB    out  1 each  datapath register load enables.
//  sel1, sel2  out  1 each  subtractor operand mux selects (1 = Aout, 0 = Bout).
//  sel_in      out  1       bus mux select (1 = data_in, 0 = SubOut).
//  busy        out  1       high from LOAD_A through DONE, inclusive.
//  done        out  1       one-cycle pulse; result sits in datapath A (== B).
//  err         out  1       valid with done: zero operand or watchdog abort.
//  iter_count  out  ITER_W  subtract cycles in the last run; held until next start.
// BEHAVIOUR
//  Reset: async to IDLE; ldA=ldB=sel1=sel2=sel_in=0, op_ready=busy=done=err=0, iter_count=0,
//   zero_flag=0. Datapath registers are not reset and are don't-care until loaded.
//  ldA/ldB/sel*/op_ready are Mealy (state + inputs, combinational); done/err/iter_count/busy are registered.
//  Every cycle in which neither load asserts: ldA=ldB=0, sel1=sel2=sel_in=0.
//  IDLE: start=1 -> LOAD_A; clear iter_count, err, zero_flag. Other inputs ignored.
//  LOAD_A: op_ready=1. If op_valid: ldA=1, sel_in=1, zero_flag|=(op_data==0) -> LOAD_B;
//   otherwise wait with no load.
//  LOAD_B: same as LOAD_A, with ldB -> CALC.
//  CALC (flags reflect registered A,B):
//   - zero_flag=1 -> DONE, err=1, no load issued.
//   - eq -> DONE, err=0.
//   - iter_count==MAX_ITER and !eq -> DONE, err=1, no load.
//   - gt -> ldA=1, sel1=1, sel2=0, sel_in=0 (A<=A-B), iter_count+1, stay in CALC.
//   - lt -> ldB=1, sel1=0, sel2=1, sel_in=0 (B<=B-A), iter_count+1, stay in CALC.
//  DONE: done=1 for exactly one cycle -> IDLE. err and iter_count then hold.
//  Latency: start -> done = 4 + N cycles with no op stalls (N = subtract count);
//   each op_valid-low cycle in LOAD_x adds 1.
//  start while busy: ignored. op_valid outside LOAD_x: ignored; op_ready=0 there.
//  Only one of gt/lt/eq is assumed high; priority zero_flag > eq > watchdog > gt > lt.
//  iter_count saturates at MAX_ITER and never wraps.
//  Async reset mid-run: immediate IDLE, no done pulse, outputs return to reset values.
// TESTING
//  1. A=12, B=18, no stalls -> loads in cycles 1-2; lt (B<=6), gt (A<=6), eq;
//     done at cycle 6, err=0, iter_count=2, datapath A=6.
//  2. A=7, B=7 -> zero subtracts, done at cycle 4, iter_count=0, err=0.
//  3. A=0, B=5 -> done at cycle 4, err=1, iter_count=0, no ldA/ldB in CALC.
//  4. MAX_ITER=8: A=1, B=9 -> 8 subtracts then eq, err=0, iter_count=8 (boundary passes).
//     A=1, B=10 -> abort at count 8, err=1, done asserted.
//  5. op_valid low 3 cycles before each operand -> op_ready held, no load while low;
//     done delayed by 6 cycles vs test 1, same result.
//  6. rst_n low during CALC of a 24/36 run -> all outputs reset asynchronously, no done;
//     start issued during busy has no effect; a fresh run after reset gives 12.

Source files
------------

// File: rtl/gcd_controller.sv
// Control FSM for the subtractive GCD datapath: loads A then B over a valid/ready
// handshake, iterates subtract steps until A==B, and pulses done (with err on abort).
module gcd_controller #(
    parameter int WIDTH    = 16,
    parameter int MAX_ITER = 1024,
    parameter int ITER_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_valid,
    input  logic [WIDTH-1:0]  op_data,
    output logic              op_ready,
    input  logic              gt,
    input  logic              lt,
    input  logic              eq,
    output logic              ldA,
    output logic              ldB,
    output logic              sel1,
    output logic              sel2,
    output logic              sel_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    state_t state;
    logic   zero_flag;
    logic   at_limit;

    assign at_limit = (iter_count == ITER_LIMIT);

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        op_ready = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        sel1     = 1'b0;
        sel2     = 1'b0;
        sel_in   = 1'b0;
        case (state)
            LOAD_A: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    ldA    = 1'b1;
                    sel_in = 1'b1;
                end
            end
            LOAD_B: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    ldB    = 1'b1;
                    sel_in = 1'b1;
                end
            end
            CALC: begin
                // Zero operand, equality and watchdog all end the run without a load.
                if (!zero_flag && !eq && !at_limit) begin
                    if (gt) begin
                        ldA  = 1'b1;
                        sel1 = 1'b1;
                    end else if (lt) begin
                        ldB  = 1'b1;
                        sel2 = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            zero_flag  <= 1'b0;
            iter_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD_A;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        zero_flag  <= 1'b0;
                        iter_count <= '0;
                    end
                end
                LOAD_A: begin
                    if (op_valid) begin
                        zero_flag <= zero_flag | (op_data == '0);
                        state     <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (op_valid) begin
                        zero_flag <= zero_flag | (op_data == '0);
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (zero_flag) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (eq) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b0;
                    end else if (at_limit) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (gt || lt) begin
                        iter_count <= iter_count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: behavioural subtractive datapath around the FSM, directed
// runs with a scoreboard of expected latency/err/iter_count/result, checked at done.
module tb_gcd_controller;

    localparam int WIDTH    = 16;
    localparam int MAX_ITER = 8;
    localparam int ITER_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              op_valid = 1'b0;
    logic [WIDTH-1:0]  op_data = '0;
    logic              op_ready;
    logic              gt, lt, eq;
    logic              ldA, ldB, sel1, sel2, sel_in;
    logic              busy, done, err;
    logic [ITER_W-1:0] iter_count;

    gcd_controller #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_data(op_data),
        .op_ready(op_ready), .gt(gt), .lt(lt), .eq(eq), .ldA(ldA), .ldB(ldB),
        .sel1(sel1), .sel2(sel2), .sel_in(sel_in), .busy(busy), .done(done), .err(err),
        .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // Datapath: A/B registers, subtractor with operand muxes, bus mux, comparator.
    logic [WIDTH-1:0] a_reg = '0;
    logic [WIDTH-1:0] b_reg = '0;
    logic [WIDTH-1:0] sub_out, bus;
    assign sub_out = (sel1 ? a_reg : b_reg) - (sel2 ? a_reg : b_reg);
    assign bus     = sel_in ? op_data : sub_out;
    assign gt      = a_reg > b_reg;
    assign lt      = a_reg < b_reg;
    assign eq      = a_reg == b_reg;
    always @(posedge clk) begin
        if (ldA) a_reg <= bus;
        if (ldB) b_reg <= bus;
    end

    typedef struct {
        int               lat;
        logic             err;
        int               iter;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   edges = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic feed_op(input logic [WIDTH-1:0] v, input int stalls, input logic is_a);
        op_valid = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            #1;
            chk("stall_op_ready", 32'(op_ready), 32'd1);
            chk("stall_no_load", 32'(is_a ? ldA : ldB), 32'd0);
            tick();
        end
        op_valid = 1'b1;
        op_data  = v;
        #1;
        chk("load_op_ready", 32'(op_ready), 32'd1);
        chk("load_strobe", 32'(is_a ? ldA : ldB), 32'd1);
        chk("load_sel_in", 32'(sel_in), 32'd1);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic do_run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int stalls,
                          input logic exp_err, input int exp_iter, input logic [WIDTH-1:0] exp_res,
                          input int exp_lat);
        exp_t e;
        int   loads;
        sb.push_back('{exp_lat, exp_err, exp_iter, exp_res});
        edges = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("iter_cleared", 32'(iter_count), 32'd0);
        feed_op(a, stalls, 1'b1);
        feed_op(b, stalls, 1'b0);
        loads = 0;
        while (!done && edges < 64) begin
            if (ldA || ldB) loads++;
            tick();
        end
        chk("done_seen", 32'(done), 32'd1);
        e = sb.pop_front();
        chk("latency", 32'(edges), 32'(e.lat));
        chk("err", 32'(err), 32'(e.err));
        chk("iter_count", 32'(iter_count), 32'(e.iter));
        chk("calc_loads", 32'(loads), 32'(e.iter));
        chk("result_a", 32'(a_reg), 32'(e.res));
        chk("busy_at_done", 32'(busy), 32'd1);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("iter_hold", 32'(iter_count), 32'(e.iter));
        chk("err_hold", 32'(err), 32'(e.err));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_iter", 32'(iter_count), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_loads", 32'({ldA, ldB, sel1, sel2, sel_in}), 32'd0);
        rst_n = 1'b1;
        tick();

        do_run(16'd12, 16'd18, 0, 1'b0, 2, 16'd6, 6);    // basic gcd
        do_run(16'd7,  16'd7,  0, 1'b0, 0, 16'd7, 4);    // equal operands
        do_run(16'd0,  16'd5,  0, 1'b1, 0, 16'd0, 4);    // zero operand guard
        do_run(16'd1,  16'd9,  0, 1'b0, 8, 16'd1, 12);   // watchdog boundary passes
        do_run(16'd1,  16'd10, 0, 1'b1, 8, 16'd1, 12);   // watchdog abort
        do_run(16'd12, 16'd18, 3, 1'b0, 2, 16'd6, 12);   // operand stalls

        // Reset mid-run, with a start pulse while busy
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_op(16'd24, 0, 1'b1);
        feed_op(16'd36, 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("busy_start_ignored", 32'(busy), 32'd1);
        chk("busy_no_op_ready", 32'(op_ready), 32'd0);
        chk("calc_second_step_ldA", 32'(ldA), 32'd1);
        chk("calc_iter_one", 32'(iter_count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_iter", 32'(iter_count), 32'd0);
        chk("arst_loads", 32'({ldA, ldB, sel1, sel2, sel_in, op_ready}), 32'd0);
        tick();
        tick();
        chk("arst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);
        do_run(16'd24, 16'd36, 0, 1'b0, 2, 16'd12, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
